zbt_port_arbiter: RTL and testbench
===================================

Name: zbt_port_arbiter

Overview:
- Shares the single 36-bit ZBT SRAM port between three requesters: the VGA display reader (r0), the gaussian_blurrer pixel fetch (r1) and the blurred-frame writer (r2).
- Grants at most one access per cycle and registers it onto the SRAM pins.
- Compensates the ZBT pipeline: write data is delayed to match, and read data plus a valid strobe are returned to the requester that issued the read.
- Sits between the image-processing blocks and the ZBT pin driver.

Parameters:
ADDR_W, 19, SRAM word address width ({x,y} packed pixel address)
DATA_W, 36, SRAM word width
READ_LATENCY, 2, cycles from address on pins to mem_rdata valid; also the write-data lag
R0_BURST_MAX, 8, consecutive r0 grants allowed while r1/r2 wait

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
r0_req, r1_req, r2_req  in  1 each  access request, held until granted
r0_we, r1_we, r2_we  in  1 each  1 = write, 0 = read
r0_addr, r1_addr, r2_addr  in  ADDR_W each  word address
r0_wdata, r1_wdata, r2_wdata  in  DATA_W each  write data, sampled in the grant cycle
r0_gnt, r1_gnt, r2_gnt  out  1 each  combinational grant; the request is consumed this cycle
r0_rvalid, r1_rvalid, r2_rvalid  out  1 each  rdata valid for this requester, one-cycle pulse
rdata  out  DATA_W  registered copy of mem_rdata, shared by all requesters
mem_addr  out  ADDR_W  registered SRAM address
mem_we  out  1  registered SRAM write enable, active-high
mem_wdata  out  DATA_W  SRAM write data, presented READ_LATENCY cycles after its address
mem_rdata  in  DATA_W  SRAM read data

Behaviour:
- Reset (reset=0, asynchronous): all gnt forced 0 while asserted.
  - mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, all rvalid=0.
  - Tag pipeline cleared, so in-flight reads are dropped with no rvalid.
  - RR pointer=r1, burst counter=0.
- Grant, same cycle as req:
  - r0 wins if requesting, unless the burst counter equals R0_BURST_MAX and r1 or r2 is requesting.
  - Otherwise r1/r2 are served round-robin from the pointer; the pointer moves to the other low requester after any r1/r2 grant.
  - If the pointed-to requester is idle, the other one is granted.
  - Exactly one gnt at most per cycle; no grant when no req.
- Burst counter: +1 on each r0 grant while r1_req|r2_req; reset to 0 on any r1/r2 grant or when no low request is pending; saturates at R0_BURST_MAX.
- Issue (edge T ending a grant cycle): mem_addr<=addr, mem_we<=we. Without a grant: mem_we<=0 and mem_addr holds its value.
- Write: wdata enters the tag pipeline; mem_wdata is driven at T+READ_LATENCY (ZBT late-write). Otherwise mem_wdata holds its last value.
- Read: a tag {valid, id} enters the pipeline at T. mem_rdata is registered into rdata and the matching rX_rvalid pulses at T+READ_LATENCY+1. Total latency from the grant cycle to rvalid is READ_LATENCY+2 edges.
- Back-to-back mixed reads and writes are allowed every cycle. The pipeline depth is fixed, so there are no bubbles or turnaround cycles.
- Releasing reset mid-frame: the arbiter restarts cleanly. Requesters are responsible for re-issuing lost reads.

Decomposition:
- Shared package zbt_pkg: ADDR_W, DATA_W, READ_LATENCY, requester id encoding (REQ_DISP=0, REQ_BLUR=1, REQ_WRITE=2), tag width.
- One sub-module, zbt_tag_pipe: a READ_LATENCY-deep shift register carrying {rd_valid, id[1:0], wr_valid, wdata} with async active-low clear.

Test Plan:
- Reset then single read: r1 read addr 0x00123, mem_rdata model returns 0xABCDE0123 → r1_gnt in the same cycle, mem_we=0 and mem_addr=0x00123 after 1 edge, r1_rvalid pulses once with rdata=0xABCDE0123 after 4 edges; r0 and r2 rvalid stay 0.
- Write timing: r2 write addr 0x7FFFF, data 0x123456789 → mem_we=1 and mem_addr=0x7FFFF at T+1, mem_wdata=0x123456789 at T+1+READ_LATENCY; no rvalid.
- Contention: r0, r1 and r2 all held high → r0 gets 8 consecutive grants, then r1 once, then r0 ×8, then r2; the grant pattern repeats.
- Round-robin: only r1 and r2 held high for 6 cycles → grants go r1,r2,r1,r2,r1,r2.
- Interleaved reads: r0 and r1 reads on alternate cycles with distinct data → every rvalid reaches the correct requester with the data for its own address; no lost or duplicate pulses.
- Reset mid-flight: reset asserted 1 cycle after a read grant → no rvalid ever; after release, a new r0 read completes normally.

Source files
------------

// File: rtl/zbt_pkg.sv
// Shared constants and requester identifiers for the ZBT SRAM port arbiter.
package zbt_pkg;

   localparam int unsigned ADDR_W       = 19;
   localparam int unsigned DATA_W       = 36;
   localparam int unsigned READ_LATENCY = 2;
   localparam int unsigned R0_BURST_MAX = 8;

   // Requester id width and tag layout: {rd_valid, id[1:0], wr_valid, wdata}
   localparam int unsigned ID_W  = 2;
   localparam int unsigned TAG_W = DATA_W + ID_W + 2;

   typedef enum logic [1:0] {
      REQ_DISP  = 2'd0,
      REQ_BLUR  = 2'd1,
      REQ_WRITE = 2'd2
   } req_id_e;

   // One-hot rvalid vector {r2, r1, r0} for a requester id
   function automatic logic [2:0] id_onehot(input req_id_e id);
      case (id)
         REQ_DISP:  return 3'b001;
         REQ_BLUR:  return 3'b010;
         REQ_WRITE: return 3'b100;
         default:   return 3'b000;
      endcase
   endfunction

endpackage

// File: rtl/zbt_tag_pipe.sv
// Fixed-depth shift register carrying per-access tags through the ZBT pipeline.
module zbt_tag_pipe #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned W     = 40
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] tag_in,
   output logic [W-1:0] tag_out
);

   logic [W-1:0] stage_q [DEPTH];
   logic [W-1:0] stage_d [DEPTH];

   // Shift one stage per cycle; a new tag enters every cycle
   always_comb begin
      stage_d[0] = tag_in;
      for (int unsigned i = 1; i < DEPTH; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   // Pipeline registers; clearing drops every in-flight access
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q <= stage_d;
      end
   end

   assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/zbt_port_arbiter.sv
// Three-way arbiter for the single ZBT SRAM port: display reader (r0) has
// priority with a burst limit, blur fetch (r1) and frame writer (r2) share
// round-robin. Write data and read returns are aligned to the ZBT pipeline.
module zbt_port_arbiter #(
   parameter int unsigned ADDR_W       = zbt_pkg::ADDR_W,
   parameter int unsigned DATA_W       = zbt_pkg::DATA_W,
   parameter int unsigned READ_LATENCY = zbt_pkg::READ_LATENCY,
   parameter int unsigned R0_BURST_MAX = zbt_pkg::R0_BURST_MAX
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              r0_req,
   input  logic              r1_req,
   input  logic              r2_req,
   input  logic              r0_we,
   input  logic              r1_we,
   input  logic              r2_we,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [ADDR_W-1:0] r2_addr,
   input  logic [DATA_W-1:0] r0_wdata,
   input  logic [DATA_W-1:0] r1_wdata,
   input  logic [DATA_W-1:0] r2_wdata,
   output logic              r0_gnt,
   output logic              r1_gnt,
   output logic              r2_gnt,
   output logic              r0_rvalid,
   output logic              r1_rvalid,
   output logic              r2_rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   import zbt_pkg::req_id_e;
   import zbt_pkg::REQ_DISP;
   import zbt_pkg::REQ_BLUR;
   import zbt_pkg::REQ_WRITE;
   import zbt_pkg::ID_W;
   import zbt_pkg::id_onehot;

   localparam int unsigned TAG_W   = DATA_W + ID_W + 2;
   localparam int unsigned BURST_W = $clog2(R0_BURST_MAX + 1);

   // Arbitration state
   req_id_e              rr_ptr_q, rr_ptr_d;
   logic [BURST_W-1:0]   burst_cnt_q, burst_cnt_d;

   // Issue registers
   logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
   logic                 mem_we_q, mem_we_d;
   logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;

   // Read return registers
   logic                 rd_valid_q, rd_valid_d;
   req_id_e              rd_id_q, rd_id_d;
   logic [DATA_W-1:0]    rdata_q, rdata_d;
   logic [2:0]           rvalid_q, rvalid_d;

   logic [2:0]           gnt_vec;
   logic                 gnt_any;
   logic                 low_req;
   logic                 burst_full;

   req_id_e              sel_id;
   logic                 sel_we;
   logic [ADDR_W-1:0]    sel_addr;
   logic [DATA_W-1:0]    sel_wdata;

   logic [TAG_W-1:0]     tag_in;
   logic [TAG_W-1:0]     tag_out;
   logic                 pipe_rd;
   logic                 pipe_wr;
   req_id_e              pipe_id;
   logic [DATA_W-1:0]    pipe_wdata;

   assign low_req    = r1_req | r2_req;
   assign burst_full = (burst_cnt_q == BURST_W'(R0_BURST_MAX));
   assign gnt_any    = |gnt_vec;

   // Grant selection: r0 first unless its burst is exhausted with r1/r2 waiting
   always_comb begin
      gnt_vec = 3'b000;
      if (reset) begin
         if (r0_req && !(burst_full && low_req)) begin
            gnt_vec = 3'b001;
         end else if (low_req) begin
            if (rr_ptr_q == REQ_BLUR) begin
               gnt_vec = r1_req ? 3'b010 : 3'b100;
            end else begin
               gnt_vec = r2_req ? 3'b100 : 3'b010;
            end
         end
      end
   end

   // Mux the granted requester's command
   always_comb begin
      sel_id    = REQ_DISP;
      sel_we    = r0_we;
      sel_addr  = r0_addr;
      sel_wdata = r0_wdata;
      if (gnt_vec[1]) begin
         sel_id    = REQ_BLUR;
         sel_we    = r1_we;
         sel_addr  = r1_addr;
         sel_wdata = r1_wdata;
      end else if (gnt_vec[2]) begin
         sel_id    = REQ_WRITE;
         sel_we    = r2_we;
         sel_addr  = r2_addr;
         sel_wdata = r2_wdata;
      end
   end

   // Round-robin pointer and r0 burst counter update
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (gnt_vec[1]) begin
         rr_ptr_d = REQ_WRITE;
      end else if (gnt_vec[2]) begin
         rr_ptr_d = REQ_BLUR;
      end

      burst_cnt_d = burst_cnt_q;
      if (gnt_vec[1] || gnt_vec[2] || !low_req) begin
         burst_cnt_d = '0;
      end else if (gnt_vec[0] && !burst_full) begin
         burst_cnt_d = burst_cnt_q + BURST_W'(1);
      end
   end

   // Issue onto the SRAM pins and launch the access tag
   always_comb begin
      mem_we_d   = gnt_any & sel_we;
      mem_addr_d = gnt_any ? sel_addr : mem_addr_q;
      tag_in     = {gnt_any & ~sel_we, sel_id, gnt_any & sel_we, sel_wdata};
   end

   zbt_tag_pipe #(
      .DEPTH (READ_LATENCY),
      .W     (TAG_W)
   ) u_tag_pipe (
      .clk     (clk),
      .rst_n   (reset),
      .tag_in  (tag_in),
      .tag_out (tag_out)
   );

   assign pipe_wdata = tag_out[DATA_W-1:0];
   assign pipe_wr    = tag_out[DATA_W];
   assign pipe_id    = req_id_e'(tag_out[DATA_W+1 +: ID_W]);
   assign pipe_rd    = tag_out[DATA_W+ID_W+1];

   // Late write data and read return; the extra rd stage waits for mem_rdata
   always_comb begin
      mem_wdata_d = pipe_wr ? pipe_wdata : mem_wdata_q;
      rd_valid_d  = pipe_rd;
      rd_id_d     = pipe_id;
      rdata_d     = rd_valid_q ? mem_rdata : rdata_q;
      rvalid_d    = rd_valid_q ? id_onehot(rd_id_q) : 3'b000;
   end

   // All arbiter state registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr_q    <= REQ_BLUR;
         burst_cnt_q <= '0;
         mem_addr_q  <= '0;
         mem_we_q    <= 1'b0;
         mem_wdata_q <= '0;
         rd_valid_q  <= 1'b0;
         rd_id_q     <= REQ_DISP;
         rdata_q     <= '0;
         rvalid_q    <= 3'b000;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         burst_cnt_q <= burst_cnt_d;
         mem_addr_q  <= mem_addr_d;
         mem_we_q    <= mem_we_d;
         mem_wdata_q <= mem_wdata_d;
         rd_valid_q  <= rd_valid_d;
         rd_id_q     <= rd_id_d;
         rdata_q     <= rdata_d;
         rvalid_q    <= rvalid_d;
      end
   end

   assign r0_gnt    = gnt_vec[0];
   assign r1_gnt    = gnt_vec[1];
   assign r2_gnt    = gnt_vec[2];
   assign r0_rvalid = rvalid_q[0];
   assign r1_rvalid = rvalid_q[1];
   assign r2_rvalid = rvalid_q[2];
   assign rdata     = rdata_q;
   assign mem_addr  = mem_addr_q;
   assign mem_we    = mem_we_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_zbt_port_arbiter.sv
// Directed bench for zbt_port_arbiter with a read-return scoreboard.
module tb_zbt_port_arbiter;

   import zbt_pkg::*;

   typedef struct {
      logic [1:0]        id;
      logic [DATA_W-1:0] data;
      int unsigned       due;
   } sb_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              r0_req, r1_req, r2_req;
   logic              r0_we, r1_we, r2_we;
   logic [ADDR_W-1:0] r0_addr, r1_addr, r2_addr;
   logic [DATA_W-1:0] r0_wdata, r1_wdata, r2_wdata;
   logic              r0_gnt, r1_gnt, r2_gnt;
   logic              r0_rvalid, r1_rvalid, r2_rvalid;
   logic [DATA_W-1:0] rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic [ADDR_W-1:0] ap0, ap1;
   logic [2:0]        rv;
   int unsigned       cyc = 0;
   int                tests = 0;
   int                fails = 0;
   sb_t               sb[$];

   zbt_port_arbiter #(
      .ADDR_W       (ADDR_W),
      .DATA_W       (DATA_W),
      .READ_LATENCY (READ_LATENCY),
      .R0_BURST_MAX (R0_BURST_MAX)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .r0_req    (r0_req),
      .r1_req    (r1_req),
      .r2_req    (r2_req),
      .r0_we     (r0_we),
      .r1_we     (r1_we),
      .r2_we     (r2_we),
      .r0_addr   (r0_addr),
      .r1_addr   (r1_addr),
      .r2_addr   (r2_addr),
      .r0_wdata  (r0_wdata),
      .r1_wdata  (r1_wdata),
      .r2_wdata  (r2_wdata),
      .r0_gnt    (r0_gnt),
      .r1_gnt    (r1_gnt),
      .r2_gnt    (r2_gnt),
      .r0_rvalid (r0_rvalid),
      .r1_rvalid (r1_rvalid),
      .r2_rvalid (r2_rvalid),
      .rdata     (rdata),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // SRAM model content: address-dependent word, 0x00123 -> 0xABCDE0123
   function automatic logic [DATA_W-1:0] mem_f(input logic [ADDR_W-1:0] a);
      return 36'hABCDE0000 ^ {17'd0, a};
   endfunction

   // SRAM model: data for the address on the pins appears READ_LATENCY cycles later
   always @(posedge clk) begin
      ap1 <= ap0;
      ap0 <= mem_addr;
   end
   assign mem_rdata = mem_f(ap1);

   assign rv = {r2_rvalid, r1_rvalid, r0_rvalid};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] onehot(input logic [1:0] id);
      logic [2:0] v;
      v = 3'b000;
      v[id] = 1'b1;
      return v;
   endfunction

   // One grant cycle: check the grant vector, record expected read returns
   task automatic step(input string tag, input logic [2:0] exp);
      sb_t e;
      @(negedge clk);
      chk(tag, 64'({r2_gnt, r1_gnt, r0_gnt}), 64'(exp));
      e.due = cyc + 4;
      if (exp == 3'b001 && !r0_we) begin
         e.id = 2'd0; e.data = mem_f(r0_addr); sb.push_back(e);
      end else if (exp == 3'b010 && !r1_we) begin
         e.id = 2'd1; e.data = mem_f(r1_addr); sb.push_back(e);
      end else if (exp == 3'b100 && !r2_we) begin
         e.id = 2'd2; e.data = mem_f(r2_addr); sb.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Read-return monitor: each expected return must arrive on its due cycle
   always @(negedge clk) begin : mon
      sb_t me;
      if (sb.size() != 0 && sb[0].due == cyc) begin
         me = sb.pop_front();
         chk("rvalid_route", 64'(rv), 64'(onehot(me.id)));
         chk("rdata", 64'(rdata), 64'(me.data));
      end else if (rv != 3'b000) begin
         chk("spurious_rvalid", 64'(rv), 64'd0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      r0_req = 1'b1; r1_req = 1'b1; r2_req = 1'b1;
      r0_we = 1'b0; r1_we = 1'b0; r2_we = 1'b1;
      r0_addr = '0; r1_addr = '0; r2_addr = '0;
      r0_wdata = '0; r1_wdata = '0; r2_wdata = '0;

      // Reset state with all requests asserted
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_gnt", 64'({r2_gnt, r1_gnt, r0_gnt}), 64'd0);
      chk("rst_mem_we", 64'(mem_we), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
      chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
      chk("rst_rdata", 64'(rdata), 64'd0);
      chk("rst_rvalid", 64'(rv), 64'd0);
      r0_req = 1'b0; r1_req = 1'b0; r2_req = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      idle(2);

      // Single r1 read
      r1_req = 1'b1; r1_we = 1'b0; r1_addr = 19'h00123;
      step("gnt_single_read", 3'b010);
      r1_req = 1'b0;
      chk("rd_mem_we", 64'(mem_we), 64'd0);
      chk("rd_mem_addr", 64'(mem_addr), 64'h00123);
      idle(6);

      // r2 write: address at T+1, data READ_LATENCY edges later
      r2_req = 1'b1; r2_we = 1'b1; r2_addr = 19'h7FFFF; r2_wdata = 36'h123456789;
      step("gnt_write", 3'b100);
      r2_req = 1'b0;
      chk("wr_mem_we", 64'(mem_we), 64'd1);
      chk("wr_mem_addr", 64'(mem_addr), 64'h7FFFF);
      chk("wr_wdata_early1", 64'(mem_wdata), 64'd0);
      idle(1);
      chk("wr_we_drop", 64'(mem_we), 64'd0);
      chk("wr_addr_hold", 64'(mem_addr), 64'h7FFFF);
      chk("wr_wdata_early2", 64'(mem_wdata), 64'd0);
      idle(1);
      chk("wr_wdata", 64'(mem_wdata), 64'h123456789);
      idle(4);

      // Contention: r0 bursts of 8, low requesters alternate
      r0_req = 1'b1; r0_we = 1'b0; r0_addr = 19'h000A0;
      r1_req = 1'b1; r1_we = 1'b0; r1_addr = 19'h000B1;
      r2_req = 1'b1; r2_we = 1'b1; r2_addr = 19'h12345; r2_wdata = 36'hFEDCBA987;
      for (int p = 0; p < 4; p++) begin
         for (int k = 0; k < 8; k++) step("gnt_burst_r0", 3'b001);
         step("gnt_burst_low", (p % 2 == 0) ? 3'b010 : 3'b100);
      end
      r0_req = 1'b0; r1_req = 1'b0; r2_req = 1'b0;
      idle(6);

      // Round-robin between r1 and r2
      r1_req = 1'b1; r1_we = 1'b0; r1_addr = 19'h33333;
      r2_req = 1'b1; r2_we = 1'b0; r2_addr = 19'h44444;
      for (int k = 0; k < 6; k++) step("gnt_rr", (k % 2 == 0) ? 3'b010 : 3'b100);
      r1_req = 1'b0; r2_req = 1'b0;
      idle(6);

      // Interleaved r0/r1 reads with distinct addresses
      for (int k = 0; k < 6; k++) begin
         if (k % 2 == 0) begin
            r0_req = 1'b1; r0_we = 1'b0; r0_addr = 19'h00100 + 19'(k);
            step("gnt_il_r0", 3'b001);
            r0_req = 1'b0;
         end else begin
            r1_req = 1'b1; r1_we = 1'b0; r1_addr = 19'h40200 + 19'(k);
            step("gnt_il_r1", 3'b010);
            r1_req = 1'b0;
         end
      end
      idle(6);

      // Reset one cycle after a read grant: the read must never return
      r1_req = 1'b1; r1_we = 1'b0; r1_addr = 19'h55555;
      step("gnt_pre_reset", 3'b010);
      r1_req = 1'b0;
      reset = 1'b0;
      sb.delete();
      r0_req = 1'b1; r0_we = 1'b0; r0_addr = 19'h2AAAA;
      #1;
      chk("midrst_gnt", 64'({r2_gnt, r1_gnt, r0_gnt}), 64'd0);
      chk("midrst_mem_addr", 64'(mem_addr), 64'd0);
      chk("midrst_mem_we", 64'(mem_we), 64'd0);
      chk("midrst_rvalid", 64'(rv), 64'd0);
      r0_req = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      idle(6);
      r0_req = 1'b1;
      step("gnt_post_reset", 3'b001);
      r0_req = 1'b0;
      idle(8);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
